rf_write_ctrl: RTL and testbench

- Write-port sequencer directly upstream of the 16-bit clock-enabled register bank.
- Accepts register write requests over a valid/ready handshake and buffers them in a small FIFO.
- Drains one write per cycle as a shared data bus plus a one-hot clock enable to the bank.
- Provides a forwarding lookup so readers see writes that have not yet landed in the bank.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_wr_fifo.sv | 66 ++++++
 rtl/rf_write_ctrl.sv | 83 ++++++++
 tb/tb_rf_write_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write path.
package rf_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    // Per-register clock enable for one target address.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous write buffer; exposes its contents oldest-first for the forwarding search.
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                         clk_n,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  rf_wr_t                       din,
    output rf_wr_t                       head,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count,
    output rf_wr_t [DEPTH-1:0]           age_entry,
    output logic [DEPTH-1:0]             age_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    rf_wr_t [DEPTH-1:0] mem;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    always_ff @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == CW'(DEPTH));

    // Slot k holds the k-th oldest buffered write.
    always_comb begin
        age_entry = '0;
        age_valid = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            age_entry[k] = mem[rd_ptr + PW'(k)];
            age_valid[k] = (CW'(k) < count);
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Write-port sequencer for the clock-enabled register bank: buffers writes,
// drains one per cycle as data bus + one-hot enable, and forwards pending data.
module rf_write_ctrl
    import rf_pkg::*;
(
    input  logic                clk_n,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                drain_en,
    input  logic                flush,
    output logic [DATA_W-1:0]   rf_D,
    output logic [NUM_REGS-1:0] rf_clk_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                fwd_hit,
    output logic [DATA_W-1:0]   fwd_data,
    output logic [CNT_W-1:0]    pending
);

    logic                     push;
    logic                     pop;
    logic                     full;
    logic [CNT_W-1:0]         count;
    rf_wr_t                   din;
    rf_wr_t                   head;
    rf_wr_t [FIFO_DEPTH-1:0]  age_entry;
    logic [FIFO_DEPTH-1:0]    age_valid;

    // Ready ignores a same-cycle pop so a full buffer always refuses.
    assign wr_ready = !full;
    assign push     = wr_valid && !full && !flush;
    assign pop      = (count != '0) && drain_en && !flush;
    assign din      = '{addr: wr_addr, data: wr_data};
    assign pending  = count;

    rf_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_n     (clk_n),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .din       (din),
        .head      (head),
        .full      (full),
        .count     (count),
        .age_entry (age_entry),
        .age_valid (age_valid)
    );

    // Output stage: enable pulses for one cycle per pop, data bus holds otherwise.
    always_ff @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            rf_D      <= '0;
            rf_clk_en <= '0;
        end else if (pop) begin
            rf_D      <= head.data;
            rf_clk_en <= onehot(head.addr);
        end else begin
            rf_clk_en <= '0;
        end
    end

    // Youngest match wins: output stage first, then buffer entries oldest to youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (rf_clk_en[rd_addr]) begin
            fwd_hit  = 1'b1;
            fwd_data = rf_D;
        end
        for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
            if (age_valid[k] && (age_entry[k].addr == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = age_entry[k].data;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Self-checking bench for rf_write_ctrl against a queue-based transaction model.
module tb_rf_write_ctrl;
    import rf_pkg::*;

    logic               clk_n;
    logic               rst_n;
    logic               wr_valid;
    logic               wr_ready;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               drain_en;
    logic               flush;
    logic [DATA_W-1:0]  rf_D;
    logic [NUM_REGS-1:0] rf_clk_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               fwd_hit;
    logic [DATA_W-1:0]  fwd_data;
    logic [CNT_W-1:0]   pending;

    rf_write_ctrl dut (
        .clk_n     (clk_n),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .drain_en  (drain_en),
        .flush     (flush),
        .rf_D      (rf_D),
        .rf_clk_en (rf_clk_en),
        .rd_addr   (rd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .pending   (pending)
    );

    initial clk_n = 1'b0;
    always #5 clk_n = ~clk_n;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  m_en;
    logic [15:0] m_D;
    int          total = 0;
    int          bad   = 0;

    // Advance one clock edge, updating the model from the inputs presented at that edge.
    task automatic cyc();
        ent_t e;
        bit   push, pop;
        push = wr_valid && (q.size() < 4) && !flush;
        pop  = (q.size() != 0) && drain_en && !flush;
        m_en = 8'h00;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) begin
                e    = q.pop_front();
                m_en = 8'(1) << e.a;
                m_D  = e.d;
            end
            if (push) begin
                e.a = wr_addr;
                e.d = wr_data;
                q.push_back(e);
            end
        end
        @(posedge clk_n);
        #1;
    endtask

    function automatic void mfwd(input logic [2:0] a, output bit hit, output logic [15:0] d);
        hit = 0;
        d   = 16'h0;
        if (m_en[a]) begin
            hit = 1;
            d   = m_D;
        end
        foreach (q[i]) begin
            if (q[i].a == a) begin
                hit = 1;
                d   = q[i].d;
            end
        end
    endfunction

    task automatic model_reset();
        q.delete();
        m_en = 8'h00;
        m_D  = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; wr_valid = 0; drain_en = 0; flush = 0;
        wr_addr = 0; wr_data = 0; rd_addr = 0;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        total++; if (rf_clk_en !== 8'h00) begin bad++; $display("FAIL reset_en got=%h want=00", rf_clk_en); end
        total++; if (rf_D !== 16'h0) begin bad++; $display("FAIL reset_D got=%h want=0000", rf_D); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", wr_ready); end
        repeat (2) @(posedge clk_n);
        #1 rst_n = 1'b1;
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", pending); end
        total++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin bad++; $display("FAIL reset_fwd got=%b/%h want=0/0000", fwd_hit, fwd_data); end
    endtask

    task automatic test_single();
        drain_en = 1; wr_valid = 1; wr_addr = 3'd3; wr_data = 16'h1111;
        cyc();
        wr_valid = 0;
        total++; if (rf_clk_en !== 8'h00 || pending !== 3'd1) begin bad++; $display("FAIL single_accept en=%h pend=%0d want 00/1", rf_clk_en, pending); end
        cyc();
        total++; if (rf_clk_en !== 8'b0000_1000 || rf_D !== 16'h1111) begin bad++; $display("FAIL single_pulse en=%h D=%h want 08/1111", rf_clk_en, rf_D); end
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL single_pending got=%0d want=0", pending); end
        cyc();
        total++; if (rf_clk_en !== 8'h00 || rf_D !== 16'h1111) begin bad++; $display("FAIL single_after en=%h D=%h want 00/1111", rf_clk_en, rf_D); end
    endtask

    task automatic test_fill();
        logic [15:0] dv [5];
        dv[0] = 16'h0000; dv[1] = 16'h1111; dv[2] = 16'h2222; dv[3] = 16'h4444; dv[4] = 16'h8888;
        drain_en = 0;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1; wr_addr = 3'(k); wr_data = dv[k];
            cyc();
        end
        total++; if (pending !== 3'd4 || wr_ready !== 1'b0) begin bad++; $display("FAIL fill_full pend=%0d rdy=%b want 4/0", pending, wr_ready); end
        wr_addr = 3'd4; wr_data = dv[4];
        cyc();
        total++; if (pending !== 3'd4) begin bad++; $display("FAIL fill_held pend=%0d want 4", pending); end
        drain_en = 1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 1) wr_valid = 0;
            total++;
            if (rf_clk_en !== (8'(1) << k) || rf_D !== dv[k]) begin
                bad++; $display("FAIL fill_drain%0d en=%h D=%h want %h/%h", k, rf_clk_en, rf_D, 8'(1) << k, dv[k]);
            end
        end
        cyc();
        total++; if (rf_clk_en !== 8'h00 || pending !== 3'd0) begin bad++; $display("FAIL fill_end en=%h pend=%0d want 00/0", rf_clk_en, pending); end
    endtask

    task automatic test_forward();
        drain_en = 0; wr_valid = 1; wr_addr = 3'd5; wr_data = 16'hcccc;
        cyc();
        wr_data = 16'hffff;
        cyc();
        wr_valid = 0; rd_addr = 3'd5;
        #1;
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 16'hffff) begin bad++; $display("FAIL fwd_young got=%b/%h want 1/ffff", fwd_hit, fwd_data); end
        rd_addr = 3'd6;
        #1;
        total++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin bad++; $display("FAIL fwd_miss got=%b/%h want 0/0000", fwd_hit, fwd_data); end
        rd_addr = 3'd5; drain_en = 1;
        cyc();
        total++; if (rf_clk_en !== 8'h20 || rf_D !== 16'hcccc || fwd_data !== 16'hffff) begin bad++; $display("FAIL fwd_drain1 en=%h D=%h fwd=%h want 20/cccc/ffff", rf_clk_en, rf_D, fwd_data); end
        cyc();
        total++; if (rf_clk_en !== 8'h20 || rf_D !== 16'hffff || fwd_hit !== 1'b1 || fwd_data !== 16'hffff) begin bad++; $display("FAIL fwd_drain2 en=%h D=%h fwd=%b/%h want 20/ffff/1/ffff", rf_clk_en, rf_D, fwd_hit, fwd_data); end
        cyc();
        total++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0) begin bad++; $display("FAIL fwd_done got=%b/%h want 0/0000", fwd_hit, fwd_data); end
    endtask

    task automatic test_flush();
        drain_en = 0;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1; wr_addr = 3'(k + 1); wr_data = 16'($urandom);
            cyc();
        end
        total++; if (pending !== 3'd3) begin bad++; $display("FAIL flush_pre pend=%0d want 3", pending); end
        flush = 1; wr_valid = 1; wr_addr = 3'd7; wr_data = 16'hdead; drain_en = 1;
        cyc();
        flush = 0; wr_valid = 0; rd_addr = 3'd7;
        #1;
        total++; if (pending !== 3'd0 || rf_clk_en !== 8'h00) begin bad++; $display("FAIL flush_edge pend=%0d en=%h want 0/00", pending, rf_clk_en); end
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL flush_discard hit=%b want 0", fwd_hit); end
        cyc();
        total++; if (rf_clk_en !== 8'h00 || pending !== 3'd0) begin bad++; $display("FAIL flush_after en=%h pend=%0d want 00/0", rf_clk_en, pending); end
    endtask

    task automatic test_back_to_back();
        drain_en = 1; wr_valid = 1; wr_addr = 3'($urandom); wr_data = 16'($urandom);
        cyc();
        for (int k = 0; k < 10; k++) begin
            wr_addr = 3'($urandom); wr_data = 16'($urandom);
            cyc();
            total++;
            if (pending !== 3'd1 || $countones(rf_clk_en) != 1 || rf_clk_en !== m_en || rf_D !== m_D) begin
                bad++; $display("FAIL stream%0d pend=%0d en=%h D=%h want 1/%h/%h", k, pending, rf_clk_en, rf_D, m_en, m_D);
            end
        end
        wr_valid = 0;
        cyc();
        cyc();
    endtask

    task automatic test_random();
        bit          h;
        logic [15:0] d;
        for (int k = 0; k < 300; k++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 3'($urandom);
            wr_data  = 16'($urandom);
            drain_en = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 19) == 0);
            rd_addr  = 3'($urandom);
            cyc();
            mfwd(rd_addr, h, d);
            total++;
            if (rf_clk_en !== m_en || rf_D !== m_D) begin
                bad++; $display("FAIL rand_out%0d en=%h D=%h want %h/%h", k, rf_clk_en, rf_D, m_en, m_D);
            end
            total++;
            if (pending !== 3'(q.size()) || wr_ready !== (q.size() < 4)) begin
                bad++; $display("FAIL rand_occ%0d pend=%0d rdy=%b want %0d", k, pending, wr_ready, q.size());
            end
            total++;
            if (fwd_hit !== h || fwd_data !== d) begin
                bad++; $display("FAIL rand_fwd%0d got=%b/%h want %b/%h", k, fwd_hit, fwd_data, h, d);
            end
        end
        flush = 0; wr_valid = 0; drain_en = 1;
        repeat (6) cyc();
    endtask

    task automatic test_async_reset();
        drain_en = 0;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1; wr_addr = (k == 0) ? 3'd2 : 3'($urandom); wr_data = 16'($urandom);
            cyc();
        end
        wr_valid = 0; drain_en = 1;
        cyc();
        total++; if (rf_clk_en !== 8'h04 || pending !== 3'd3) begin bad++; $display("FAIL areset_pre en=%h pend=%0d want 04/3", rf_clk_en, pending); end
        rst_n = 1'b0;
        #1;
        total++; if (rf_clk_en !== 8'h00 || wr_ready !== 1'b1) begin bad++; $display("FAIL areset_async en=%h rdy=%b want 00/1", rf_clk_en, wr_ready); end
        model_reset();
        @(posedge clk_n);
        #1 rst_n = 1'b1;
        total++; if (pending !== 3'd0 || fwd_hit !== 1'b0) begin bad++; $display("FAIL areset_post pend=%0d hit=%b want 0/0", pending, fwd_hit); end
        cyc();
        total++; if (rf_clk_en !== 8'h00) begin bad++; $display("FAIL areset_lost en=%h want 00", rf_clk_en); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
